// File: rtl/tl_log_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tl_log_arbiter
// Brief    : Round-robin merge of TileLink log records into one stamped FIFO
//            that drains one record per cycle to the log writer.
// Revision : 1.0
// ============================================================================
module tl_log_arbiter #(
    parameter int          NUM_PORTS         = 5,
    parameter int          DEPTH             = 8,
    // Elaborate-time test hooks; the defaults give normal behaviour.
    parameter int          DRAIN_HOLD_CYCLES = 0,
    parameter logic [31:0] DROP_RESET_VALUE  = 32'd0,
    localparam int         REC_W             = 488
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       log_enable,
    input  logic [NUM_PORTS-1:0]       req_valid,
    output logic [NUM_PORTS-1:0]       req_ready,
    input  logic [NUM_PORTS*REC_W-1:0] req_rec,
    output logic                       out_en,
    output logic [7:0]                 out_channel,
    output logic [7:0]                 out_opcode,
    output logic [7:0]                 out_param,
    output logic [7:0]                 out_source,
    output logic [7:0]                 out_sink,
    output logic [63:0]                out_address,
    output logic [63:0]                out_data_0,
    output logic [63:0]                out_data_1,
    output logic [63:0]                out_data_2,
    output logic [63:0]                out_data_3,
    output logic [63:0]                out_user,
    output logic [63:0]                out_echo,
    output logic [63:0]                out_stamp,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [31:0]                drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SEL_W = $clog2(NUM_PORTS);
    localparam int PC_W  = $clog2(NUM_PORTS + 1);
    localparam int ENT_W = REC_W + 64;

    localparam logic [CNT_W-1:0] c_DEPTH     = CNT_W'(DEPTH);
    localparam logic [SEL_W-1:0] c_LAST_INIT = SEL_W'(NUM_PORTS - 1);

    logic [ENT_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [SEL_W-1:0]     r_last_grant;
    logic [63:0]          r_stamp;
    logic [31:0]          r_drop;

    logic [NUM_PORTS-1:0] w_grant;
    logic [SEL_W-1:0]     w_grant_idx;
    logic                 w_found;
    logic                 w_not_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_hold;
    logic [REC_W-1:0]     w_push_rec;
    logic [ENT_W-1:0]     w_head;
    logic [PC_W-1:0]      w_valid_cnt;
    logic [32:0]          w_drop_sum;
    logic [31:0]          w_drop_next;

    function automatic int rr_index(input int last, input int k);
        int i;
        i = last + 1 + k;
        if (i >= NUM_PORTS) begin
            i = i - NUM_PORTS;
        end
        return i;
    endfunction

    // Search starts one past the last granted port.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!w_found && req_valid[rr_index(int'(r_last_grant), k)]) begin
                w_found     = 1'b1;
                w_grant[rr_index(int'(r_last_grant), k)] = 1'b1;
                w_grant_idx = SEL_W'(rr_index(int'(r_last_grant), k));
            end
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign w_not_full = (r_count < c_DEPTH);
    assign w_push     = log_enable && w_not_full && w_found;
    assign w_pop      = (r_count != '0) && !w_hold;
    assign w_push_rec = req_rec[int'(w_grant_idx)*REC_W +: REC_W];
    assign w_head     = r_mem[r_rd_ptr];

    always_comb begin
        req_ready = '0;
        if (!log_enable) begin
            req_ready = req_valid;
        end else if (w_not_full) begin
            req_ready = w_grant;
        end
    end

    always_comb begin
        w_valid_cnt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_valid_cnt = w_valid_cnt + PC_W'(req_valid[i]);
        end
        w_drop_sum  = {1'b0, r_drop} + 33'(w_valid_cnt);
        w_drop_next = w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
    end

    generate
        if (DRAIN_HOLD_CYCLES > 0) begin : g_hold
            localparam int HOLD_W = $clog2(DRAIN_HOLD_CYCLES + 1);
            logic [HOLD_W-1:0] r_hold;
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_hold <= HOLD_W'(DRAIN_HOLD_CYCLES);
                end else if (r_hold != '0) begin
                    r_hold <= r_hold - HOLD_W'(1);
                end
            end
            assign w_hold = (r_hold != '0);
        end else begin : g_no_hold
            assign w_hold = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_stamp, w_push_rec};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_last_grant <= c_LAST_INIT;
            r_stamp      <= '0;
            r_drop       <= DROP_RESET_VALUE;
            out_en       <= 1'b0;
            out_channel  <= '0;
            out_opcode   <= '0;
            out_param    <= '0;
            out_source   <= '0;
            out_sink     <= '0;
            out_address  <= '0;
            out_data_0   <= '0;
            out_data_1   <= '0;
            out_data_2   <= '0;
            out_data_3   <= '0;
            out_user     <= '0;
            out_echo     <= '0;
            out_stamp    <= '0;
        end else begin
            r_stamp <= r_stamp + 64'd1;
            if (!log_enable) begin
                r_drop <= w_drop_next;
            end
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
                r_last_grant <= w_grant_idx;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            out_en <= w_pop;
            if (w_pop) begin
                out_channel <= w_head[7:0];
                out_opcode  <= w_head[15:8];
                out_param   <= w_head[23:16];
                out_source  <= w_head[31:24];
                out_sink    <= w_head[39:32];
                out_address <= w_head[103:40];
                out_data_0  <= w_head[167:104];
                out_data_1  <= w_head[231:168];
                out_data_2  <= w_head[295:232];
                out_data_3  <= w_head[359:296];
                out_user    <= w_head[423:360];
                out_echo    <= w_head[487:424];
                out_stamp   <= w_head[ENT_W-1:REC_W];
            end
        end
    end

    assign fifo_count = r_count;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_tl_log_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_log_arbiter
// Brief    : Directed self-checking bench for tl_log_arbiter.
// Revision : 1.0
// ============================================================================
module tb_tl_log_arbiter;

    localparam int NP = 5;
    localparam int RW = 488;

    localparam logic [7:0]  c_PARAM  = 8'h5A;
    localparam logic [7:0]  c_SOURCE = 8'hC3;
    localparam logic [7:0]  c_SINK   = 8'h3C;
    localparam logic [63:0] c_DATA0  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] c_DATA1  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] c_DATA2  = 64'h5555_6666_7777_8888;
    localparam logic [63:0] c_DATA3  = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] c_USER   = 64'hA5A5_0000_5A5A_FFFF;
    localparam logic [63:0] c_ECHO   = 64'hEC40_1234_5678_9ABC;
    localparam logic [31:0] c_DROP_PRESET = 32'hFFFF_FFFA;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Main instance (default parameters)
    logic              reset, log_enable;
    logic [NP-1:0]     req_valid, req_ready;
    logic [NP*RW-1:0]  req_rec;
    logic              out_en;
    logic [7:0]        out_channel, out_opcode, out_param, out_source, out_sink;
    logic [63:0]       out_address, out_data_0, out_data_1, out_data_2, out_data_3;
    logic [63:0]       out_user, out_echo, out_stamp;
    logic [3:0]        fifo_count;
    logic [31:0]       drop_count;

    // Hooked instance: drain held off after reset, drop counter preset near saturation
    logic              h_reset, h_log_enable;
    logic [NP-1:0]     h_req_valid, h_req_ready;
    logic [NP*RW-1:0]  h_req_rec;
    logic              h_out_en;
    logic [7:0]        h_out_channel, h_out_opcode, h_out_param, h_out_source, h_out_sink;
    logic [63:0]       h_out_address, h_out_data_0, h_out_data_1, h_out_data_2, h_out_data_3;
    logic [63:0]       h_out_user, h_out_echo, h_out_stamp;
    logic [3:0]        h_fifo_count;
    logic [31:0]       h_drop_count;

    tl_log_arbiter #(.NUM_PORTS(NP), .DEPTH(8)) dut (
        .clock(clock), .reset(reset), .log_enable(log_enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_rec(req_rec),
        .out_en(out_en), .out_channel(out_channel), .out_opcode(out_opcode),
        .out_param(out_param), .out_source(out_source), .out_sink(out_sink),
        .out_address(out_address), .out_data_0(out_data_0), .out_data_1(out_data_1),
        .out_data_2(out_data_2), .out_data_3(out_data_3), .out_user(out_user),
        .out_echo(out_echo), .out_stamp(out_stamp),
        .fifo_count(fifo_count), .drop_count(drop_count)
    );

    tl_log_arbiter #(.NUM_PORTS(NP), .DEPTH(8), .DRAIN_HOLD_CYCLES(20),
                     .DROP_RESET_VALUE(c_DROP_PRESET)) dut_h (
        .clock(clock), .reset(h_reset), .log_enable(h_log_enable),
        .req_valid(h_req_valid), .req_ready(h_req_ready), .req_rec(h_req_rec),
        .out_en(h_out_en), .out_channel(h_out_channel), .out_opcode(h_out_opcode),
        .out_param(h_out_param), .out_source(h_out_source), .out_sink(h_out_sink),
        .out_address(h_out_address), .out_data_0(h_out_data_0), .out_data_1(h_out_data_1),
        .out_data_2(h_out_data_2), .out_data_3(h_out_data_3), .out_user(h_out_user),
        .out_echo(h_out_echo), .out_stamp(h_out_stamp),
        .fifo_count(h_fifo_count), .drop_count(h_drop_count)
    );

    function automatic logic [RW-1:0] mkrec(input logic [7:0] ch, input logic [7:0] op,
                                            input logic [63:0] addr);
        return {c_ECHO, c_USER, c_DATA3, c_DATA2, c_DATA1, c_DATA0, addr,
                c_SINK, c_SOURCE, c_PARAM, op, ch};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_port(input int p, input logic [7:0] op, input logic [63:0] addr);
        req_rec[p*RW +: RW] = mkrec(8'(p), op, addr);
    endtask

    task automatic set_hport(input int p, input logic [7:0] op, input logic [63:0] addr);
        h_req_rec[p*RW +: RW] = mkrec(8'(p), op, addr);
    endtask

    // Leaves the main instance in cycle 0 (stamp 0) with reset deasserted.
    task automatic main_reset;
        reset = 1'b1; log_enable = 1'b1; req_valid = '0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic h_main_reset;
        h_reset = 1'b1; h_log_enable = 1'b1; h_req_valid = '0;
        tick; tick;
        h_reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; log_enable = 1'b1; req_valid = '0;
        tick; tick;
        checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en got %0b exp 0", out_en); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
        checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL reset_drop_count got %0h exp 0", drop_count); end
        checks++; if (out_stamp !== 64'd0) begin errors++; $display("FAIL reset_out_stamp got %0h exp 0", out_stamp); end
        checks++; if (out_address !== 64'd0) begin errors++; $display("FAIL reset_out_address got %0h exp 0", out_address); end
        checks++; if (req_ready !== 5'b00000) begin errors++; $display("FAIL reset_req_ready got %b exp 00000", req_ready); end
        reset = 1'b0;
    endtask

    task automatic test_single;
        main_reset();
        repeat (10) tick;
        set_port(2, 8'h04, 64'h1000);
        req_valid = 5'b00100;
        #1;
        checks++; if (req_ready !== 5'b00100) begin errors++; $display("FAIL single_ready got %b exp 00100", req_ready); end
        tick;
        req_valid = '0;
        checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL single_en_t11 got %0b exp 0", out_en); end
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count_t11 got %0d exp 1", fifo_count); end
        tick;
        checks++; if (out_en !== 1'b1) begin errors++; $display("FAIL single_en_t12 got %0b exp 1", out_en); end
        checks++; if (out_address !== 64'h1000) begin errors++; $display("FAIL single_address got %0h exp 1000", out_address); end
        checks++; if (out_opcode !== 8'h04) begin errors++; $display("FAIL single_opcode got %0h exp 4", out_opcode); end
        checks++; if (out_stamp !== 64'd10) begin errors++; $display("FAIL single_stamp got %0d exp 10", out_stamp); end
        checks++; if (out_channel !== 8'd2) begin errors++; $display("FAIL single_channel got %0h exp 2", out_channel); end
        checks++; if (out_param !== c_PARAM) begin errors++; $display("FAIL single_param got %0h exp %0h", out_param, c_PARAM); end
        checks++; if (out_source !== c_SOURCE) begin errors++; $display("FAIL single_source got %0h exp %0h", out_source, c_SOURCE); end
        checks++; if (out_sink !== c_SINK) begin errors++; $display("FAIL single_sink got %0h exp %0h", out_sink, c_SINK); end
        checks++; if (out_data_0 !== c_DATA0) begin errors++; $display("FAIL single_data0 got %0h exp %0h", out_data_0, c_DATA0); end
        checks++; if (out_data_1 !== c_DATA1) begin errors++; $display("FAIL single_data1 got %0h exp %0h", out_data_1, c_DATA1); end
        checks++; if (out_data_2 !== c_DATA2) begin errors++; $display("FAIL single_data2 got %0h exp %0h", out_data_2, c_DATA2); end
        checks++; if (out_data_3 !== c_DATA3) begin errors++; $display("FAIL single_data3 got %0h exp %0h", out_data_3, c_DATA3); end
        checks++; if (out_user !== c_USER) begin errors++; $display("FAIL single_user got %0h exp %0h", out_user, c_USER); end
        checks++; if (out_echo !== c_ECHO) begin errors++; $display("FAIL single_echo got %0h exp %0h", out_echo, c_ECHO); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count_t12 got %0d exp 0", fifo_count); end
        tick;
        checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL single_en_t13 got %0b exp 0", out_en); end
        checks++; if (out_address !== 64'h1000) begin errors++; $display("FAIL single_hold_address got %0h exp 1000", out_address); end
    endtask

    task automatic test_round_robin;
        logic [NP-1:0] exp_ready;
        reset = 1'b1; log_enable = 1'b1;
        for (int p = 0; p < NP; p++) set_port(p, 8'(p + 16), 64'(p * 256));
        req_valid = '1;
        tick; tick;
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_ready = 5'b00001 << (c % 5);
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready c%0d got %b exp %b", c, req_ready, exp_ready); end
            if (c >= 2) begin
                checks++; if (out_en !== 1'b1) begin errors++; $display("FAIL rr_en c%0d got %0b exp 1", c, out_en); end
                checks++; if (out_channel !== 8'((c - 2) % 5)) begin errors++; $display("FAIL rr_channel c%0d got %0d exp %0d", c, out_channel, (c - 2) % 5); end
                checks++; if (out_stamp !== 64'(c - 2)) begin errors++; $display("FAIL rr_stamp c%0d got %0d exp %0d", c, out_stamp, c - 2); end
            end
            tick;
        end
        req_valid = '0;
        tick; tick; tick;
    endtask

    task automatic test_disable;
        main_reset();
        tick; tick;
        log_enable = 1'b0;
        req_valid = 5'b01011;
        for (int d = 0; d < 3; d++) begin
            #1;
            checks++; if (req_ready !== 5'b01011) begin errors++; $display("FAIL dis_ready d%0d got %b exp 01011", d, req_ready); end
            checks++; if (drop_count !== 32'(3 * d)) begin errors++; $display("FAIL dis_drop d%0d got %0d exp %0d", d, drop_count, 3 * d); end
            checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL dis_en d%0d got %0b exp 0", d, out_en); end
            tick;
        end
        log_enable = 1'b1;
        req_valid = '0;
        checks++; if (drop_count !== 32'd9) begin errors++; $display("FAIL dis_drop_total got %0d exp 9", drop_count); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL dis_count got %0d exp 0", fifo_count); end
        tick; tick;
        checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL dis_en_after got %0b exp 0", out_en); end
        checks++; if (drop_count !== 32'd9) begin errors++; $display("FAIL dis_drop_hold got %0d exp 9", drop_count); end
    endtask

    task automatic test_saturation;
        logic [31:0] exp_drop [3];
        exp_drop[0] = 32'hFFFF_FFFD; exp_drop[1] = 32'hFFFF_FFFF; exp_drop[2] = 32'hFFFF_FFFF;
        h_main_reset();
        checks++; if (h_drop_count !== c_DROP_PRESET) begin errors++; $display("FAIL sat_preset got %0h exp %0h", h_drop_count, c_DROP_PRESET); end
        h_log_enable = 1'b0;
        h_req_valid = 5'b00111;
        for (int d = 0; d < 3; d++) begin
            #1;
            checks++; if (h_req_ready !== 5'b00111) begin errors++; $display("FAIL sat_ready d%0d got %b exp 00111", d, h_req_ready); end
            tick;
            checks++; if (h_drop_count !== exp_drop[d]) begin errors++; $display("FAIL sat_drop d%0d got %0h exp %0h", d, h_drop_count, exp_drop[d]); end
        end
        h_log_enable = 1'b1;
        h_req_valid = '0;
        checks++; if (h_fifo_count !== 4'd0) begin errors++; $display("FAIL sat_count got %0d exp 0", h_fifo_count); end
    endtask

    // Continues on dut_h from cycle 3; drain is held until cycle 20.
    task automatic test_full_backpressure;
        logic [NP-1:0] exp_ready;
        int            exp_count;
        set_hport(0, 8'hA0, 64'hAAAA);
        set_hport(1, 8'hB1, 64'hBBBB);
        h_req_valid = 5'b00011;
        for (int c = 3; c < 15; c++) begin
            #1;
            exp_ready = (c <= 10) ? (5'b00001 << ((c - 3) % 2)) : 5'b00000;
            exp_count = (c - 3 < 8) ? c - 3 : 8;
            checks++; if (h_req_ready !== exp_ready) begin errors++; $display("FAIL full_ready c%0d got %b exp %b", c, h_req_ready, exp_ready); end
            checks++; if (h_fifo_count !== 4'(exp_count)) begin errors++; $display("FAIL full_count c%0d got %0d exp %0d", c, h_fifo_count, exp_count); end
            tick;
        end
        h_req_valid = '0;
        repeat (5) tick;
        checks++; if (h_out_en !== 1'b0) begin errors++; $display("FAIL full_held_en got %0b exp 0", h_out_en); end
        tick;
        for (int k = 0; k < 8; k++) begin
            checks++; if (h_out_en !== 1'b1) begin errors++; $display("FAIL full_drain_en k%0d got %0b exp 1", k, h_out_en); end
            checks++; if (h_out_channel !== 8'(k % 2)) begin errors++; $display("FAIL full_drain_channel k%0d got %0d exp %0d", k, h_out_channel, k % 2); end
            checks++; if (h_out_stamp !== 64'(3 + k)) begin errors++; $display("FAIL full_drain_stamp k%0d got %0d exp %0d", k, h_out_stamp, 3 + k); end
            checks++; if (h_fifo_count !== 4'(7 - k)) begin errors++; $display("FAIL full_drain_count k%0d got %0d exp %0d", k, h_fifo_count, 7 - k); end
            tick;
        end
        checks++; if (h_out_en !== 1'b0) begin errors++; $display("FAIL full_after_en got %0b exp 0", h_out_en); end
    endtask

    task automatic test_reset_mid;
        h_main_reset();
        set_hport(3, 8'h33, 64'h3333);
        h_req_valid = 5'b01000;
        repeat (5) tick;
        h_req_valid = '0;
        #1;
        checks++; if (h_fifo_count !== 4'd5) begin errors++; $display("FAIL mid_count_pre got %0d exp 5", h_fifo_count); end
        h_reset = 1'b1;
        tick;
        checks++; if (h_out_en !== 1'b0) begin errors++; $display("FAIL mid_en got %0b exp 0", h_out_en); end
        checks++; if (h_fifo_count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", h_fifo_count); end
        checks++; if (h_out_stamp !== 64'd0) begin errors++; $display("FAIL mid_out_stamp got %0h exp 0", h_out_stamp); end
        checks++; if (h_drop_count !== c_DROP_PRESET) begin errors++; $display("FAIL mid_drop got %0h exp %0h", h_drop_count, c_DROP_PRESET); end
        h_reset = 1'b0;
        for (int p = 0; p < NP; p++) set_hport(p, 8'(p), 64'(p + 64'h7000));
        h_req_valid = '1;
        #1;
        checks++; if (h_req_ready !== 5'b00001) begin errors++; $display("FAIL mid_first_grant got %b exp 00001", h_req_ready); end
        tick;
        h_req_valid = '0;
        checks++; if (h_fifo_count !== 4'd1) begin errors++; $display("FAIL mid_post_count got %0d exp 1", h_fifo_count); end
        repeat (20) tick;
        checks++; if (h_out_en !== 1'b1) begin errors++; $display("FAIL mid_post_en got %0b exp 1", h_out_en); end
        checks++; if (h_out_channel !== 8'd0) begin errors++; $display("FAIL mid_post_channel got %0d exp 0", h_out_channel); end
        checks++; if (h_out_stamp !== 64'd0) begin errors++; $display("FAIL mid_post_stamp got %0d exp 0", h_out_stamp); end
        checks++; if (h_out_address !== 64'h7000) begin errors++; $display("FAIL mid_post_address got %0h exp 7000", h_out_address); end
    endtask

    initial begin
        reset = 1'b1; log_enable = 1'b1; req_valid = '0; req_rec = '0;
        h_reset = 1'b1; h_log_enable = 1'b1; h_req_valid = '0; h_req_rec = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_disable();
        test_saturation();
        test_full_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1);
    end

endmodule
`default_nettype wire
